// File: rtl/sar_async_sequencer_if.sv
// Bus bundle between the SAR sequencer and its comparator / DAC / result consumer.
interface sar_async_sequencer_if #(
  parameter int unsigned N_BITS = 8
);
  logic              start;
  logic              comp_valid;
  logic              comp_p;
  logic              sample_en;
  logic              comp_en;
  logic [N_BITS-1:0] dac_code;
  logic [N_BITS-1:0] data_out;
  logic              done;
  logic              busy;
  logic              timeout_flag;

  // Controller/comparator side: drives requests and comparator results.
  modport master (
    output start, comp_valid, comp_p,
    input  sample_en, comp_en, dac_code, data_out, done, busy, timeout_flag
  );

  // Sequencer side.
  modport slave (
    input  start, comp_valid, comp_p,
    output sample_en, comp_en, dac_code, data_out, done, busy, timeout_flag
  );
endinterface

// File: rtl/sar_async_sequencer.sv
// SAR ADC conversion sequencer: sample phase, one comparator decision per bit
// (MSB first), final code presentation. Comparator inputs are asynchronous and
// are synchronised here. Optional COMPARE watchdog enabled by SAR_TIMEOUT_EN.
module sar_async_sequencer #(
  parameter int unsigned N_BITS         = 8,
  parameter int unsigned SAMPLE_CYCLES  = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sar_async_sequencer_if.slave  bus
);

  localparam int unsigned IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int unsigned CNT_MAX = (SAMPLE_CYCLES > TIMEOUT_CYCLES) ? SAMPLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SAMPLE  = 3'd1,
    S_COMPARE = 3'd2,
    S_RESOLVE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_BITS-1:0]   dac_q, dac_d;
  logic [N_BITS-1:0]   data_q, data_d;
  logic                sample_en_q, sample_en_d;
  logic                comp_en_q, comp_en_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [SYNC_STAGES-1:0] v_sync;
  logic [SYNC_STAGES-1:0] p_sync;
  logic                   v_d;
  logic                   v_s;
  logic                   p_s;
  logic                   v_rise;

  assign v_s    = v_sync[SYNC_STAGES-1];
  assign p_s    = p_sync[SYNC_STAGES-1];
  assign v_rise = v_s & ~v_d;

  // Equal-depth synchronisers keep comp_p aligned with comp_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_sync <= '0;
      p_sync <= '0;
      v_d    <= 1'b0;
    end else begin
      v_sync <= {v_sync[SYNC_STAGES-2:0], bus.comp_valid};
      p_sync <= {p_sync[SYNC_STAGES-2:0], bus.comp_p};
      v_d    <= v_s;
    end
  end

`ifdef SAR_TIMEOUT_EN
  logic tflag_q, tflag_d;
`endif

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dac_d   = dac_q;
    data_d  = data_q;
`ifdef SAR_TIMEOUT_EN
    tflag_d = tflag_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d = S_SAMPLE;
          dac_d   = '0;
`ifdef SAR_TIMEOUT_EN
          tflag_d = 1'b0;
`endif
        end
      end

      S_SAMPLE: begin
        if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
          state_d           = S_COMPARE;
          dac_d             = '0;
          dac_d[N_BITS-1]   = 1'b1;
          idx_d             = IDX_W'(N_BITS - 1);
          cnt_d             = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Only a fresh rising edge is a decision; a stale high level is ignored.
      S_COMPARE: begin
        if (v_rise) begin
          dac_d[idx_q] = p_s;
          state_d      = S_RESOLVE;
`ifdef SAR_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          dac_d[idx_q] = 1'b0;
          tflag_d      = 1'b1;
          state_d      = S_RESOLVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end

      // Wait for the comparator to reset before the next trial.
      S_RESOLVE: begin
        if (!v_s) begin
          if (idx_q == '0) begin
            state_d = S_DONE;
            data_d  = dac_q;
          end else begin
            idx_d                       = idx_q - IDX_W'(1);
            dac_d[idx_q - IDX_W'(1)]    = 1'b1;
            cnt_d                       = '0;
            state_d                     = S_COMPARE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    sample_en_d = (state_d == S_SAMPLE);
    comp_en_d   = (state_d == S_COMPARE);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= IDX_W'(N_BITS - 1);
      cnt_q       <= '0;
      dac_q       <= '0;
      data_q      <= '0;
      sample_en_q <= 1'b0;
      comp_en_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      dac_q       <= dac_d;
      data_q      <= data_d;
      sample_en_q <= sample_en_d;
      comp_en_q   <= comp_en_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SAR_TIMEOUT_EN
  // Sticky watchdog flag, cleared when a new conversion starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tflag_q <= 1'b0;
    else        tflag_q <= tflag_d;
  end
  assign bus.timeout_flag = tflag_q;
`else
  assign bus.timeout_flag = 1'b0;
`endif

  assign bus.sample_en = sample_en_q;
  assign bus.comp_en   = comp_en_q;
  assign bus.dac_code  = dac_q;
  assign bus.data_out  = data_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sar_async_sequencer.sv
// Bench for sar_async_sequencer: comparator model, trial-code and result
// scoreboards, directed scenarios. Build with SAR_TIMEOUT_EN to cover the watchdog.
module tb_sar_async_sequencer;

  localparam int unsigned N_BITS         = 8;
  localparam int unsigned SAMPLE_CYCLES  = 4;
  localparam int unsigned TIMEOUT_CYCLES = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] vin = 8'h00;
  logic       model_en = 1'b1;
  logic       manual_valid = 1'b0;
  logic       model_valid = 1'b0;
  logic       mute_msb = 1'b0;
  int         model_cnt = 0;

  int checks = 0;
  int failures = 0;
  int done_count = 0;
  int conv_base = 0;

  logic [7:0] trial_q[$];
  logic [7:0] exp_q[$];
  logic       prev_comp_en = 1'b0;
  logic       prev_done = 1'b0;

  sar_async_sequencer_if #(.N_BITS(N_BITS)) sif ();

  sar_async_sequencer #(
    .N_BITS         (N_BITS),
    .SAMPLE_CYCLES  (SAMPLE_CYCLES),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  // Ties resolve high so a trial code equal to vin is kept.
  assign sif.start      = start;
  assign sif.comp_p     = (vin >= sif.dac_code);
  assign sif.comp_valid = model_en ? model_valid : manual_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=none expected=event", tag);
  endtask

  // Comparator: resolves 3 cycles after comp_en rises, releases when it falls.
  always @(negedge clk) begin
    if (sif.comp_en === 1'b1) begin
      if (model_cnt < 3) model_cnt++;
      model_valid = (model_cnt >= 3) && !(mute_msb && sif.dac_code == 8'h80);
    end else begin
      model_cnt   = 0;
      model_valid = 1'b0;
    end
  end

  // Scoreboard: trial code at each comp_en rise, result at each done.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (sif.comp_en === 1'b1 && prev_comp_en !== 1'b1) begin
        if (trial_q.size() == 0) fail_now("trial_unexpected");
        else begin
          e = trial_q.pop_front();
          chk("trial_code", 32'(sif.dac_code), 32'(e));
        end
      end
      if (sif.done === 1'b1) begin
        chk("done_busy", 32'(sif.busy), 32'd1);
        chk("done_single", 32'(prev_done), 32'd0);
        if (exp_q.size() == 0) fail_now("done_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("data_out", 32'(sif.data_out), 32'(e));
        end
        done_count++;
      end
    end
    prev_comp_en = sif.comp_en;
    prev_done    = sif.done;
  end

  task automatic push_expect(input logic [7:0] v);
    logic [7:0] code;
    logic [7:0] trial;
    code = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      trial = code | (8'd1 << b);
      trial_q.push_back(trial);
      if (v >= trial) code = trial;
    end
    exp_q.push_back(code);
  endtask

  task automatic start_conv(input logic [7:0] v);
    int n;
    vin = v;
    push_expect(v);
    conv_base = done_count;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(sif.busy), 32'd1);
    n = 0;
    while (sif.sample_en === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("sample_len", 32'(n), 32'(SAMPLE_CYCLES));
  endtask

  task automatic wait_comp_en(input int bound);
    int n;
    n = 0;
    while (sif.comp_en !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sif.comp_en !== 1'b1) fail_now("wait_comp_en");
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_count == conv_base && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (done_count == conv_base) fail_now("wait_done");
  endtask

  task automatic convert(input logic [7:0] v);
    start_conv(v);
    wait_done();
    @(negedge clk);
    chk("busy_after_done", 32'(sif.busy), 32'd0);
    chk("data_hold", 32'(sif.data_out), 32'(v));
    chk("done_count", 32'(done_count), 32'(conv_base + 1));
    chk("tflag_normal", 32'(sif.timeout_flag), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({sif.sample_en, sif.comp_en, sif.dac_code, sif.data_out,
                              sif.done, sif.busy, sif.timeout_flag}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", 32'({sif.sample_en, sif.comp_en, sif.busy}), 32'd0);

    // Main function and bit-index boundaries.
    convert(8'hA5);
    convert(8'h00);
    convert(8'hFF);

    // start during COMPARE is ignored.
    start_conv(8'h5A);
    wait_comp_en(50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    chk("ignored_start_dones", 32'(done_count), 32'(conv_base + 1));
    chk("ignored_start_idle", 32'(sif.busy), 32'd0);
    chk("ignored_start_result", 32'(sif.data_out), 32'h5A);

    // Reset during the bit-4 trial.
    start_conv(8'h55);
    n = 0;
    while (!(sif.comp_en === 1'b1 && sif.dac_code[4:0] === 5'b10000) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("bit4_trial_code", 32'(sif.dac_code), 32'h50);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({sif.sample_en, sif.comp_en, sif.dac_code, sif.data_out,
                              sif.done, sif.busy, sif.timeout_flag}), 32'd0);
    trial_q.delete();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", 32'(done_count), 32'(conv_base));
    convert(8'h3C);

    // Stale comp_valid level on COMPARE entry.
    model_en     = 1'b0;
    manual_valid = 1'b1;
    repeat (3) @(negedge clk);
    start_conv(8'h12);
    wait_comp_en(50);
    repeat (4) @(negedge clk);
    chk("stale_hold_en", 32'(sif.comp_en), 32'd1);
    chk("stale_hold_code", 32'(sif.dac_code), 32'h80);
    manual_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("stale_low_en", 32'(sif.comp_en), 32'd1);
    chk("stale_low_code", 32'(sif.dac_code), 32'h80);
    model_en = 1'b1;
    wait_done();
    @(negedge clk);
    chk("stale_result", 32'(sif.data_out), 32'h12);
    chk("stale_tflag", 32'(sif.timeout_flag), 32'd0);

`ifdef SAR_TIMEOUT_EN
    // MSB decision never resolves; watchdog forces it to 0.
    mute_msb = 1'b1;
    start_conv(8'h7F);
    wait_comp_en(50);
    n = 1;
    while (sif.comp_en === 1'b1 && n < 100) begin
      @(negedge clk);
      if (sif.comp_en === 1'b1) n++;
    end
    chk("timeout_len", 32'(n), 32'(TIMEOUT_CYCLES));
    mute_msb = 1'b0;
    wait_done();
    @(negedge clk);
    chk("timeout_result", 32'(sif.data_out), 32'h7F);
    chk("timeout_flag_set", 32'(sif.timeout_flag), 32'd1);
    start_conv(8'h11);
    chk("timeout_flag_clear", 32'(sif.timeout_flag), 32'd0);
    wait_done();
    @(negedge clk);
    chk("after_timeout_result", 32'(sif.data_out), 32'h11);
`else
    chk("tflag_tied", 32'(sif.timeout_flag), 32'd0);
`endif

    repeat (5) @(negedge clk);
    chk("queues_drained", 32'(trial_q.size() + exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
